// File: rtl/gn_mdl_axis_pkg.sv
// Shared types and helpers for the AXI4-Stream master/slave models.
// The FSM state type is exported so benches and checkers can watch the master's phase.
package gn_mdl_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } axis_mst_st_t;

  localparam int unsigned LP_PCT_RANGE = 100;

  // xorshift32 step: cheap pseudo-random source standing in for $urandom in hardware
  function automatic logic [31:0] rng_next(input logic [31:0] s);
    logic [31:0] x;
    x = s ^ (s << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

endpackage

// File: rtl/gn_mdl_rand_hold_gen.sv
// Random hold-period permit generator: a gap counter reloads with a random period in
// [P_MIN, P_MAX] at zero, and at each reload the permit is redrawn with P_PCT % chance.
module gn_mdl_rand_hold_gen
  import gn_mdl_axis_pkg::*;
#(
  parameter int unsigned P_MIN  = 1,
  parameter int unsigned P_MAX  = 8,
  parameter int unsigned P_PCT  = 100,
  parameter logic [31:0] P_SEED = 32'h1d87_2b41
) (
  input  logic clk,
  input  logic reset,
  output logic permit
);

  localparam int unsigned LP_GW   = $clog2(P_MAX + 1);
  localparam int unsigned LP_SPAN = P_MAX - P_MIN + 1;

  logic [31:0]      rng_q;
  logic [LP_GW-1:0] gap_q;
  logic             permit_q;
  logic [31:0]      reload_w;
  logic             grant_w;

  // Low half of the random word picks the period, high half picks the permit draw.
  assign reload_w = P_MIN + (32'(rng_q[15:0]) % LP_SPAN);
  assign grant_w  = (32'(rng_q[31:16]) % LP_PCT_RANGE) < P_PCT;

  always_ff @(posedge clk) begin
    if (reset) begin
      rng_q    <= P_SEED;
      gap_q    <= '0;
      permit_q <= 1'b0;
    end else begin
      rng_q <= rng_next(rng_q);
      if (gap_q == '0) begin
        gap_q    <= reload_w[LP_GW-1:0];
        permit_q <= grant_w;
      end else begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  assign permit = permit_q;

endmodule

// File: rtl/gn_mdl_axis_mst.sv
// AXI4-Stream master model: on start, emits num_words incrementing beats from start_data,
// with tvalid throttled by a random hold-period permit. busy/done let a sequence chain bursts.
module gn_mdl_axis_mst
  import gn_mdl_axis_pkg::*;
#(
  parameter int unsigned P_DWIDTH          = 32,
  parameter int unsigned P_MAX_WORDS       = 256,
  parameter int unsigned P_TVLD_MIN_CYC    = 1,
  parameter int unsigned P_TVLD_MAX_CYC    = 8,
  parameter int unsigned P_TVLD_ASSERT_PCT = 100,
  localparam int unsigned LP_CW            = $clog2(P_MAX_WORDS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LP_CW-1:0]    num_words,
  input  logic [P_DWIDTH-1:0] start_data,
  output logic                busy,
  output logic                done,
  output logic [P_DWIDTH-1:0] tx_axis_tdata,
  output logic                tx_axis_tvalid,
  input  logic                tx_axis_tready,
  output axis_mst_st_t        dbg_state
);

  // Handshake: a beat transfers on a rising clk edge where tvalid & tready are both 1.
  // tvalid is a register; once raised it holds with tdata until that transfer happens.

  axis_mst_st_t        state_q, state_n;
  logic [LP_CW-1:0]    rem_q, rem_n;
  logic [P_DWIDTH-1:0] data_q, data_n;
  logic                tvalid_q, tvalid_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                permit;
  logic [LP_CW-1:0]    num_clamped;

  gn_mdl_rand_hold_gen #(
    .P_MIN (P_TVLD_MIN_CYC),
    .P_MAX (P_TVLD_MAX_CYC),
    .P_PCT (P_TVLD_ASSERT_PCT)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .permit (permit)
  );

  assign num_clamped = (num_words > LP_CW'(P_MAX_WORDS)) ? LP_CW'(P_MAX_WORDS) : num_words;

  always_comb begin
    state_n  = state_q;
    rem_n    = rem_q;
    data_n   = data_q;
    tvalid_n = tvalid_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_n = ST_FIN;
            done_n  = 1'b1;
          end else begin
            state_n = ST_RUN;
            rem_n   = num_clamped;
            data_n  = start_data;
            busy_n  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (tvalid_q && tx_axis_tready) begin
          data_n = data_q + P_DWIDTH'(1);
          rem_n  = rem_q - 1'b1;
          if (rem_q == LP_CW'(1)) begin
            state_n  = ST_FIN;
            tvalid_n = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else begin
            tvalid_n = permit;
          end
        end else if (!tvalid_q) begin
          // Only an idle bus may pick up the permit; a pending beat is never withdrawn.
          tvalid_n = permit;
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n  = ST_IDLE;
        tvalid_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      data_q   <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      rem_q    <= rem_n;
      data_q   <= data_n;
      tvalid_q <= tvalid_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign tx_axis_tdata  = data_q;
  assign tx_axis_tvalid = tvalid_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_gn_mdl_axis_mst.sv
// Bench for gn_mdl_axis_mst: an always-permit instance for exact timing checks and a
// 50% throttled instance for a full 256-beat random burst, both against queue models.
module tb_gn_mdl_axis_mst;
  import gn_mdl_axis_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned MW = 256;
  localparam int unsigned CW = $clog2(MW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: permit always granted
  logic          a_reset = 1'b1, a_start = 1'b0, a_tready = 1'b1;
  logic [CW-1:0] a_num = '0;
  logic [W-1:0]  a_d0 = '0, a_tdata;
  logic          a_busy, a_done, a_tvalid;
  axis_mst_st_t  a_state;
  // instance b: permit granted half the time
  logic          b_reset = 1'b1, b_start = 1'b0, b_tready = 1'b0;
  logic [CW-1:0] b_num = '0;
  logic [W-1:0]  b_d0 = '0, b_tdata;
  logic          b_busy, b_done, b_tvalid;
  axis_mst_st_t  b_state;

  gn_mdl_axis_mst #(.P_DWIDTH(W), .P_MAX_WORDS(MW), .P_TVLD_ASSERT_PCT(100)) u_dut (
    .clk(clk), .reset(a_reset), .start(a_start), .num_words(a_num), .start_data(a_d0),
    .busy(a_busy), .done(a_done), .tx_axis_tdata(a_tdata), .tx_axis_tvalid(a_tvalid),
    .tx_axis_tready(a_tready), .dbg_state(a_state));

  gn_mdl_axis_mst #(.P_DWIDTH(W), .P_MAX_WORDS(MW), .P_TVLD_ASSERT_PCT(50)) u_dut_r (
    .clk(clk), .reset(b_reset), .start(b_start), .num_words(b_num), .start_data(b_d0),
    .busy(b_busy), .done(b_done), .tx_axis_tdata(b_tdata), .tx_axis_tvalid(b_tvalid),
    .tx_axis_tready(b_tready), .dbg_state(b_state));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: expected beat streams and done counts
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int a_beats = 0, b_beats = 0, a_dones = 0, b_dones = 0, a_bursts = 0, b_bursts = 0;
  logic a_stall = 1'b0, b_stall = 1'b0;
  logic [W-1:0] a_prev = '0, b_prev = '0;

  always @(negedge clk) begin
    if (a_reset) a_stall = 1'b0;
    else begin
      if (a_stall) begin
        chk("a_hold_valid", 32'(a_tvalid), 32'd1);
        chk("a_hold_data", a_tdata, a_prev);
      end
      if (a_tvalid && a_tready) begin
        chk("a_beat_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) chk("a_beat", a_tdata, exp_a.pop_front());
        a_beats++;
      end
      if (a_done) a_dones++;
      a_stall = a_tvalid && !a_tready;
      a_prev  = a_tdata;
    end
  end

  always @(negedge clk) begin
    if (b_reset) b_stall = 1'b0;
    else begin
      if (b_stall) begin
        chk("b_hold_valid", 32'(b_tvalid), 32'd1);
        chk("b_hold_data", b_tdata, b_prev);
      end
      if (b_tvalid && b_tready) begin
        chk("b_beat_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) chk("b_beat", b_tdata, exp_b.pop_front());
        b_beats++;
      end
      if (b_done) b_dones++;
      b_stall = b_tvalid && !b_tready;
      b_prev  = b_tdata;
    end
  end

  // model: a burst of n requests min(n, MW) beats counting up from d0, modulo 2^W
  task automatic send_a(input int n, input logic [W-1:0] d0);
    int cnt;
    cnt = (n > MW) ? MW : n;
    for (int i = 0; i < cnt; i++) exp_a.push_back(d0 + W'(i));
    a_bursts++;
    a_num = CW'(n);
    a_d0 = d0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!a_done && n < budget) begin
      if (rnd) a_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("a_done_seen", 32'(a_done), 32'd1);
    a_tready = 1'b1;
    tick();
    chk("a_done_one_cycle", 32'(a_done), 32'd0);
  endtask

  // exact cycle-by-cycle burst with tready held high
  task automatic run_exact_a(input int n, input logic [W-1:0] d0);
    send_a(n, d0);
    chk("x_busy_after_start", 32'(a_busy), 32'd1);
    chk("x_tvalid_after_start", 32'(a_tvalid), 32'd0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("x_tvalid", 32'(a_tvalid), 32'd1);
      chk("x_tdata", a_tdata, d0 + W'(i));
    end
    tick();
    chk("x_tvalid_end", 32'(a_tvalid), 32'd0);
    chk("x_done", 32'(a_done), 32'd1);
    chk("x_busy_end", 32'(a_busy), 32'd0);
    tick();
    chk("x_done_low", 32'(a_done), 32'd0);
    chk("x_idle", 32'(a_state), 32'(ST_IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [W-1:0] d;
    repeat (3) tick();
    chk("rst_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst_tdata", a_tdata, 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_state", 32'(a_state), 32'(ST_IDLE));
    a_reset = 1'b0;
    b_reset = 1'b0;
    repeat (3) tick();

    // back-to-back burst, then the wrap case
    run_exact_a(4, 32'h10);
    run_exact_a(4, 32'hFFFF_FFFE);

    // stall mid-burst; a start during RUN must be ignored
    send_a(6, 32'h10);
    n = 0;
    while (!(a_tvalid && a_tdata == 32'h12) && n < 50) begin tick(); n++; end
    chk("stall_reached", 32'(a_tdata), 32'h12);
    a_tready = 1'b0;
    a_start = 1'b1; a_num = CW'(2); a_d0 = 32'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_start = 1'b0;
      chk("stall_tvalid", 32'(a_tvalid), 32'd1);
      chk("stall_tdata", a_tdata, 32'h12);
    end
    a_tready = 1'b1;
    wait_done_a(100, 1'b0);

    // zero-length burst
    send_a(0, 32'h77);
    chk("zero_busy", 32'(a_busy), 32'd0);
    chk("zero_done", 32'(a_done), 32'd1);
    chk("zero_tvalid", 32'(a_tvalid), 32'd0);
    tick();
    chk("zero_done_low", 32'(a_done), 32'd0);
    chk("zero_busy_low", 32'(a_busy), 32'd0);

    // reset after two of eight beats discards the rest
    send_a(8, 32'h100);
    repeat (3) tick();
    chk("pre_rst_data", a_tdata, 32'h102);
    a_reset = 1'b1;
    tick();
    exp_a.delete();
    a_bursts--;
    chk("mid_rst_tvalid", 32'(a_tvalid), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_tdata", a_tdata, 32'd0);
    chk("mid_rst_state", 32'(a_state), 32'(ST_IDLE));
    a_reset = 1'b0;
    repeat (2) tick();
    run_exact_a(3, 32'h55);

    // oversize request is clamped
    base = a_beats;
    send_a(300, 32'h8000_0000);
    wait_done_a(3000, 1'b0);
    chk("clamp_beats", 32'(a_beats - base), 32'(MW));

    // random bursts with random tready
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 24);
      d = $urandom;
      send_a(n, d);
      wait_done_a(2000, 1'b1);
    end
    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("a_done_count", 32'(a_dones), 32'(a_bursts));

    // throttled instance: 256 beats under random tready
    d = $urandom;
    for (int i = 0; i < MW; i++) exp_b.push_back(d + W'(i));
    b_bursts++;
    b_num = CW'(MW);
    b_d0 = d;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 20000) begin
      b_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("b_done_seen", 32'(b_done), 32'd1);
    b_tready = 1'b0;
    repeat (3) tick();
    chk("b_beats", 32'(b_beats), 32'(MW));
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    chk("b_done_count", 32'(b_dones), 32'(b_bursts));
    chk("b_idle", 32'(b_state), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
